// File: rtl/ula_pkg.sv
// Shared constants for the 8-bit 74181-style ALU: function-select mnemonics, mode enum, slice width.
// Used by ula_4bit_slice and ula_8bit.
package ula_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic {
    ARITH = 1'b0,
    LOGIC = 1'b1
  } mode_e;

  // Logic-mode rows (m=1)
  localparam logic [3:0] LG_NOT_A     = 4'h0;
  localparam logic [3:0] LG_NOR       = 4'h1;
  localparam logic [3:0] LG_NA_AND_B  = 4'h2;
  localparam logic [3:0] LG_ZERO      = 4'h3;
  localparam logic [3:0] LG_NAND      = 4'h4;
  localparam logic [3:0] LG_NOT_B     = 4'h5;
  localparam logic [3:0] LG_XOR       = 4'h6;
  localparam logic [3:0] LG_A_AND_NB  = 4'h7;
  localparam logic [3:0] LG_NA_OR_B   = 4'h8;
  localparam logic [3:0] LG_XNOR      = 4'h9;
  localparam logic [3:0] LG_B         = 4'hA;
  localparam logic [3:0] LG_AND       = 4'hB;
  localparam logic [3:0] LG_ONES      = 4'hC;
  localparam logic [3:0] LG_A_OR_NB   = 4'hD;
  localparam logic [3:0] LG_OR        = 4'hE;
  localparam logic [3:0] LG_A         = 4'hF;

  // Arithmetic-mode rows (m=0), each X + Y + c_in
  localparam logic [3:0] AR_A            = 4'h0;
  localparam logic [3:0] AR_OR           = 4'h1;
  localparam logic [3:0] AR_OR_NB        = 4'h2;
  localparam logic [3:0] AR_MINUS1       = 4'h3;
  localparam logic [3:0] AR_A_P_ANB      = 4'h4;
  localparam logic [3:0] AR_OR_P_ANB     = 4'h5;
  localparam logic [3:0] AR_SUB          = 4'h6;
  localparam logic [3:0] AR_ANB_M1       = 4'h7;
  localparam logic [3:0] AR_A_P_AB       = 4'h8;
  localparam logic [3:0] AR_ADD          = 4'h9;
  localparam logic [3:0] AR_ORNB_P_AB    = 4'hA;
  localparam logic [3:0] AR_AB_M1        = 4'hB;
  localparam logic [3:0] AR_DOUBLE       = 4'hC;
  localparam logic [3:0] AR_OR_P_A       = 4'hD;
  localparam logic [3:0] AR_ORNB_P_A     = 4'hE;
  localparam logic [3:0] AR_DEC          = 4'hF;

endpackage

// File: rtl/ula_4bit_slice.sv
// Combinational 4-bit ALU slice; arithmetic is X + Y + c_in where X and Y are bitwise
// functions of a/b, so two slices chained through the carry equal the 8-bit sum.
module ula_4bit_slice
  import ula_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [3:0]         s,
  input  logic               m,
  input  logic               c_in,
  output logic [SLICE_W-1:0] f,
  output logic               c_out,
  output logic               eq
);

  logic [SLICE_W-1:0] lf;
  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W:0]   sum;
  mode_e              mode;

  assign mode = mode_e'(m);
  assign eq   = (a == b);

  always_comb begin
    lf = '0;
    case (s)
      LG_NOT_A:    lf = ~a;
      LG_NOR:      lf = ~(a | b);
      LG_NA_AND_B: lf = ~a & b;
      LG_ZERO:     lf = '0;
      LG_NAND:     lf = ~(a & b);
      LG_NOT_B:    lf = ~b;
      LG_XOR:      lf = a ^ b;
      LG_A_AND_NB: lf = a & ~b;
      LG_NA_OR_B:  lf = ~a | b;
      LG_XNOR:     lf = ~(a ^ b);
      LG_B:        lf = b;
      LG_AND:      lf = a & b;
      LG_ONES:     lf = '1;
      LG_A_OR_NB:  lf = a | ~b;
      LG_OR:       lf = a | b;
      LG_A:        lf = a;
      default:     lf = '0;
    endcase
  end

  // "+FF" rows use an all-ones Y; per nibble that is simply all ones.
  always_comb begin
    x = '0;
    y = '0;
    case (s)
      AR_A:         begin x = a;          y = '0;      end
      AR_OR:        begin x = a | b;      y = '0;      end
      AR_OR_NB:     begin x = a | ~b;     y = '0;      end
      AR_MINUS1:    begin x = '0;         y = '1;      end
      AR_A_P_ANB:   begin x = a;          y = a & ~b;  end
      AR_OR_P_ANB:  begin x = a | b;      y = a & ~b;  end
      AR_SUB:       begin x = a;          y = ~b;      end
      AR_ANB_M1:    begin x = a & ~b;     y = '1;      end
      AR_A_P_AB:    begin x = a;          y = a & b;   end
      AR_ADD:       begin x = a;          y = b;       end
      AR_ORNB_P_AB: begin x = a | ~b;     y = a & b;   end
      AR_AB_M1:     begin x = a & b;      y = '1;      end
      AR_DOUBLE:    begin x = a;          y = a;       end
      AR_OR_P_A:    begin x = a | b;      y = a;       end
      AR_ORNB_P_A:  begin x = a | ~b;     y = a;       end
      AR_DEC:       begin x = a;          y = '1;      end
      default:      begin x = '0;         y = '0;      end
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, c_in};

  always_comb begin
    f     = '0;
    c_out = 1'b0;
    if (mode == LOGIC) begin
      f = lf;
    end else begin
      f     = sum[SLICE_W-1:0];
      c_out = sum[SLICE_W];
    end
  end

endmodule

// File: rtl/ula_8bit.sv
// 8-bit ALU execute stage: two ripple-chained 4-bit slices with registered f, c_out, a_eq_b.
// ULA_ZERO_FLAG_EN adds a registered zero flag (f == 0).
module ula_8bit
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       a_eq_b,
  output logic       c_out
`ifdef ULA_ZERO_FLAG_EN
  ,
  output logic       zero
`endif
);

  logic [7:0] f_next;
  logic       c_mid;
  logic       c_next;
  logic       eq_lo;
  logic       eq_hi;
  logic       carry_in;

  // Logic mode ignores c_in; masking it keeps the slices' carry chain quiet.
  assign carry_in = (mode_e'(m) == ARITH) ? c_in : 1'b0;

  ula_4bit_slice u_lo (
    .a     (a[3:0]),
    .b     (b[3:0]),
    .s     (s),
    .m     (m),
    .c_in  (carry_in),
    .f     (f_next[3:0]),
    .c_out (c_mid),
    .eq    (eq_lo)
  );

  ula_4bit_slice u_hi (
    .a     (a[7:4]),
    .b     (b[7:4]),
    .s     (s),
    .m     (m),
    .c_in  (c_mid),
    .f     (f_next[7:4]),
    .c_out (c_next),
    .eq    (eq_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f      <= 8'h00;
      c_out  <= 1'b0;
      a_eq_b <= 1'b0;
    end else begin
      f      <= f_next;
      c_out  <= c_next;
      a_eq_b <= eq_lo & eq_hi;
    end
  end

`ifdef ULA_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else begin
      zero <= (f_next == 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_ula_8bit.sv
// Directed bench for ula_8bit: reset, hand-computed vectors, then a 32-code sweep against a 9-bit model.
module tb_ula_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] s;
  logic       m;
  logic       c_in;
  logic [7:0] f;
  logic       a_eq_b;
  logic       c_out;
`ifdef ULA_ZERO_FLAG_EN
  logic       zero;
`endif

  int tests;
  int failed;

  ula_8bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .s      (s),
    .m      (m),
    .c_in   (c_in),
    .f      (f),
    .a_eq_b (a_eq_b),
    .c_out  (c_out)
`ifdef ULA_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation and wait until its registered result is visible.
  task automatic apply(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] ts,
                       input logic tm, input logic tc);
    a = ta; b = tb_; s = ts; m = tm; c_in = tc;
    @(posedge clk);
    #1;
  endtask

  // Reference from the function tables, computed directly at 9 bits.
  function automatic logic [8:0] golden(input logic [7:0] ga, input logic [7:0] gb,
                                        input logic [3:0] gs, input logic gm, input logic gc);
    logic [7:0] r;
    logic [8:0] x;
    logic [8:0] y;
    r = 8'h00;
    x = 9'h0;
    y = 9'h0;
    if (gm) begin
      case (gs)
        4'h0: r = ~ga;         4'h1: r = ~(ga | gb);
        4'h2: r = ~ga & gb;    4'h3: r = 8'h00;
        4'h4: r = ~(ga & gb);  4'h5: r = ~gb;
        4'h6: r = ga ^ gb;     4'h7: r = ga & ~gb;
        4'h8: r = ~ga | gb;    4'h9: r = ~(ga ^ gb);
        4'hA: r = gb;          4'hB: r = ga & gb;
        4'hC: r = 8'hFF;       4'hD: r = ga | ~gb;
        4'hE: r = ga | gb;     default: r = ga;
      endcase
      return {1'b0, r};
    end
    case (gs)
      4'h0: begin x = {1'b0, ga};        y = 9'h000;              end
      4'h1: begin x = {1'b0, ga | gb};   y = 9'h000;              end
      4'h2: begin x = {1'b0, ga | ~gb};  y = 9'h000;              end
      4'h3: begin x = 9'h000;            y = 9'h0FF;              end
      4'h4: begin x = {1'b0, ga};        y = {1'b0, ga & ~gb};    end
      4'h5: begin x = {1'b0, ga | gb};   y = {1'b0, ga & ~gb};    end
      4'h6: begin x = {1'b0, ga};        y = {1'b0, ~gb};         end
      4'h7: begin x = {1'b0, ga & ~gb};  y = 9'h0FF;              end
      4'h8: begin x = {1'b0, ga};        y = {1'b0, ga & gb};     end
      4'h9: begin x = {1'b0, ga};        y = {1'b0, gb};          end
      4'hA: begin x = {1'b0, ga | ~gb};  y = {1'b0, ga & gb};     end
      4'hB: begin x = {1'b0, ga & gb};   y = 9'h0FF;              end
      4'hC: begin x = {1'b0, ga};        y = {1'b0, ga};          end
      4'hD: begin x = {1'b0, ga | gb};   y = {1'b0, ga};          end
      4'hE: begin x = {1'b0, ga | ~gb};  y = {1'b0, ga};          end
      default: begin x = {1'b0, ga};     y = 9'h0FF;              end
    endcase
    return x + y + {8'h00, gc};
  endfunction

  logic [7:0] pa [4];
  logic [7:0] pb [4];
  logic [8:0] g;

  initial begin
    tests  = 0;
    failed = 0;
    pa = '{8'h00, 8'hFF, 8'hAA, 8'h0F};
    pb = '{8'h00, 8'h00, 8'h55, 8'h01};

    // Reset with no clock edge yet
    rst_n = 1'b0;
    a = 8'hAA; b = 8'hAA; s = 4'hC; m = 1'b1; c_in = 1'b1;
    #2;
    check("reset_f", {1'b0, f}, 9'h000);
    check("reset_c_out", {8'h00, c_out}, 9'h000);
    check("reset_eq", {8'h00, a_eq_b}, 9'h000);
`ifdef ULA_ZERO_FLAG_EN
    check("reset_zero", {8'h00, zero}, 9'h000);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Logic rows
    apply(8'hAA, 8'h55, 4'h6, 1'b1, 1'b1);
    check("xor_f", {1'b0, f}, 9'h0FF);
    check("xor_c_out", {8'h00, c_out}, 9'h000);
    apply(8'hFF, 8'h00, 4'h0, 1'b1, 1'b0);
    check("not_a_f", {1'b0, f}, 9'h000);
`ifdef ULA_ZERO_FLAG_EN
    check("not_a_zero", {8'h00, zero}, 9'h001);
`endif
    apply(8'h12, 8'h34, 4'hC, 1'b1, 1'b0);
    check("ones_f", {1'b0, f}, 9'h0FF);

    // Ripple add and subtract
    apply(8'h0F, 8'h01, 4'h9, 1'b0, 1'b0);
    check("add_ripple", {c_out, f}, 9'h010);
    apply(8'hFF, 8'h01, 4'h9, 1'b0, 1'b0);
    check("add_wrap", {c_out, f}, 9'h100);
`ifdef ULA_ZERO_FLAG_EN
    check("add_wrap_zero", {8'h00, zero}, 9'h001);
`endif
    apply(8'hAA, 8'hAA, 4'h6, 1'b0, 1'b1);
    check("sub_equal", {c_out, f}, 9'h100);
    apply(8'h00, 8'h00, 4'h6, 1'b0, 1'b0);
    check("sub_borrow", {c_out, f}, 9'h0FF);
`ifdef ULA_ZERO_FLAG_EN
    check("sub_borrow_zero", {8'h00, zero}, 9'h000);
`endif

    // Comparator
    apply(8'hAA, 8'hAA, 4'h0, 1'b1, 1'b0);
    check("eq_same", {8'h00, a_eq_b}, 9'h001);
    apply(8'hAA, 8'hAB, 4'h0, 1'b1, 1'b0);
    check("eq_diff", {8'h00, a_eq_b}, 9'h000);

    // Asynchronous reset mid-cycle, then first result after release
    apply(8'h7F, 8'h7F, 4'hC, 1'b1, 1'b0);
    check("pre_reset_f", {1'b0, f}, 9'h0FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_f", {1'b0, f}, 9'h000);
    check("midreset_eq", {8'h00, a_eq_b}, 9'h000);
    #1;
    rst_n = 1'b1;
    apply(8'h80, 8'h80, 4'h9, 1'b0, 1'b1);
    check("post_reset_add", {c_out, f}, 9'h101);
    check("post_reset_eq", {8'h00, a_eq_b}, 9'h001);

    // Sweep all codes against the model
    for (int mi = 0; mi < 2; mi++) begin
      for (int si = 0; si < 16; si++) begin
        for (int pi = 0; pi < 4; pi++) begin
          for (int ci = 0; ci < 2; ci++) begin
            apply(pa[pi], pb[pi], 4'(si), 1'(mi), 1'(ci));
            g = golden(pa[pi], pb[pi], 4'(si), 1'(mi), 1'(ci));
            check($sformatf("sweep_m%0d_s%0h_p%0d_c%0d", mi, si, pi, ci), {c_out, f}, g);
            check($sformatf("sweep_eq_p%0d", pi), {8'h00, a_eq_b}, {8'h00, pa[pi] == pb[pi]});
`ifdef ULA_ZERO_FLAG_EN
            check($sformatf("sweep_zero_m%0d_s%0h_p%0d_c%0d", mi, si, pi, ci),
                  {8'h00, zero}, {8'h00, g[7:0] == 8'h00});
`endif
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
